// File: rtl/qam_mapper.sv
// Gray-coded BPSK/QPSK/16-QAM/64-QAM mapper: collects serial coded bits and emits
// registered signed I/Q samples with a one-cycle valid strobe per completed symbol.
module qam_mapper #(
  parameter int OUT_W = 16,
  parameter int UNIT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in,
  input  logic                    encoder_en,
  input  logic [1:0]              mode,
  input  logic                    flush,
  output logic                    en,
  output logic signed [OUT_W-1:0] outx,
  output logic signed [OUT_W-1:0] outy,
  output logic                    busy
);

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;
  localparam logic [1:0] MODE_QAM64 = 2'd3;

  if (longint'(7) * longint'(UNIT) > (longint'(1) << (OUT_W - 1)) - 1) begin : g_unit_check
    $error("qam_mapper: 7*UNIT does not fit in signed OUT_W");
  end

  logic [2:0]             cnt_q, cnt_d;
  logic [5:0]             sr_q, sr_d;
  logic [1:0]             mode_q, mode_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic signed [OUT_W-1:0] outx_q, outx_d;
  logic signed [OUT_W-1:0] outy_q, outy_d;

  logic [1:0] mode_eff;
  logic [5:0] bits;
  logic [2:0] nbits;
  logic [1:0] k;
  logic [2:0] ig, qg;

  // Axis value g is right-aligned with the first-received bit as MSB; Gray->binary
  // then gives the level index directly, so level = 2*index - (2^k - 1).
  function automatic logic signed [OUT_W-1:0] axis_scale(input logic [2:0] g,
                                                         input logic [1:0] kk);
    logic [2:0] bin;
    int         lvl;
    bin = g ^ (g >> 1) ^ (g >> 2);
    lvl = 2 * int'(bin) - ((1 << kk) - 1);
    return OUT_W'(lvl * UNIT);
  endfunction

  always_comb begin
    mode_eff = (cnt_q == 3'd0) ? mode : mode_q;

    bits = sr_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (cnt_q == 3'(i)) bits[i] = in;
    end

    nbits = 3'd1;
    k     = 2'd1;
    ig    = {2'b00, bits[0]};
    qg    = '0;
    case (mode_eff)
      MODE_BPSK: begin
        nbits = 3'd1;
        k     = 2'd1;
        ig    = {2'b00, bits[0]};
      end
      MODE_QPSK: begin
        nbits = 3'd2;
        k     = 2'd1;
        ig    = {2'b00, bits[0]};
        qg    = {2'b00, bits[1]};
      end
      MODE_QAM16: begin
        nbits = 3'd4;
        k     = 2'd2;
        ig    = {1'b0, bits[0], bits[1]};
        qg    = {1'b0, bits[2], bits[3]};
      end
      MODE_QAM64: begin
        nbits = 3'd6;
        k     = 2'd3;
        ig    = {bits[0], bits[1], bits[2]};
        qg    = {bits[3], bits[4], bits[5]};
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    mode_d = mode_q;
    en_d   = 1'b0;
    outx_d = outx_q;
    outy_d = outy_q;
    if (flush) begin
      cnt_d = '0;
    end else if (encoder_en) begin
      sr_d = bits;
      if (cnt_q == 3'd0) mode_d = mode;
      if (cnt_q + 3'd1 == nbits) begin
        cnt_d  = '0;
        en_d   = 1'b1;
        outx_d = axis_scale(ig, k);
        outy_d = (mode_eff == MODE_BPSK) ? '0 : axis_scale(qg, k);
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    busy_d = (cnt_d != 3'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      mode_q <= MODE_BPSK;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      outx_q <= '0;
      outy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      outx_q <= outx_d;
      outy_q <= outy_d;
    end
  end

  assign en   = en_q;
  assign outx = outx_q;
  assign outy = outy_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: hand-computed symbols for every mode, mode latching,
// gaps, flush and asynchronous reset.
module tb_qam_mapper;

  logic               clk;
  logic               reset;
  logic               in_bit;
  logic               encoder_en;
  logic [1:0]         mode;
  logic               flush;
  logic               en;
  logic signed [15:0] outx;
  logic signed [15:0] outy;
  logic               busy;

  int unsigned tests_run;
  int unsigned tests_failed;

  qam_mapper #(.OUT_W(16), .UNIT(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_bit),
    .encoder_en (encoder_en),
    .mode       (mode),
    .flush      (flush),
    .en         (en),
    .outx       (outx),
    .outy       (outy),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic b);
    mode       = m;
    in_bit     = b;
    encoder_en = 1'b1;
    step();
    encoder_en = 1'b0;
  endtask

  task automatic expect_sym(input string tag, input int x, input int y);
    check({tag, ".en"}, en, 1);
    check({tag, ".x"}, outx, x);
    check({tag, ".y"}, outy, y);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    in_bit       = 1'b0;
    encoder_en   = 1'b0;
    mode         = 2'd0;
    flush        = 1'b0;
    repeat (3) step();
    check("rst.en", en, 0);
    check("rst.x", outx, 0);
    check("rst.y", outy, 0);
    check("rst.busy", busy, 0);
    reset = 1'b0;
    step();

    // QPSK 1,0
    send(2'd1, 1'b1);
    check("qpsk.busy1", busy, 1);
    check("qpsk.en1", en, 0);
    send(2'd1, 1'b0);
    expect_sym("qpsk", 1024, -1024);
    check("qpsk.busy2", busy, 0);
    step();
    check("qpsk.en_drop", en, 0);
    check("qpsk.hold_x", outx, 1024);

    // 16-QAM 1,0,0,1
    send(2'd2, 1'b1);
    send(2'd2, 1'b0);
    send(2'd2, 1'b0);
    check("q16.en3", en, 0);
    send(2'd2, 1'b1);
    expect_sym("q16", 3072, -1024);

    // 64-QAM 1,0,0,0,1,1
    send(2'd3, 1'b1);
    send(2'd3, 1'b0);
    send(2'd3, 1'b0);
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    check("q64.en5", en, 0);
    send(2'd3, 1'b1);
    expect_sym("q64", 7168, -3072);

    // BPSK 0,1,1 back to back
    send(2'd0, 1'b0);
    expect_sym("bpsk0", -1024, 0);
    send(2'd0, 1'b1);
    expect_sym("bpsk1", 1024, 0);
    send(2'd0, 1'b1);
    expect_sym("bpsk2", 1024, 0);
    step();
    check("bpsk.en_drop", en, 0);

    // Mode change mid-symbol: 64-QAM 0,1,1,1,1,0 with mode switched to QPSK after bit 2
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    check("latch.en2", en, 0);
    send(2'd1, 1'b1);
    check("latch.en3", en, 0);
    send(2'd1, 1'b1);
    check("latch.en4", en, 0);
    send(2'd1, 1'b1);
    send(2'd1, 1'b0);
    expect_sym("latch", -3072, 1024);
    send(2'd1, 1'b0);
    check("latch.next_en1", en, 0);
    send(2'd1, 1'b1);
    expect_sym("latch.next", -1024, 1024);

    // 16-QAM with gap then flush colliding with a bit
    send(2'd2, 1'b1);
    send(2'd2, 1'b1);
    repeat (5) step();
    check("gap.busy", busy, 1);
    check("gap.en", en, 0);
    flush      = 1'b1;
    in_bit     = 1'b1;
    encoder_en = 1'b1;
    step();
    flush      = 1'b0;
    encoder_en = 1'b0;
    check("flush.busy", busy, 0);
    check("flush.en", en, 0);
    check("flush.hold_x", outx, -1024);
    check("flush.hold_y", outy, 1024);
    send(2'd2, 1'b0);
    check("flush.en1", en, 0);
    send(2'd2, 1'b0);
    check("flush.en2", en, 0);
    send(2'd2, 1'b0);
    check("flush.en3", en, 0);
    send(2'd2, 1'b0);
    expect_sym("flush", -3072, -3072);

    // Asynchronous reset mid 64-QAM symbol
    send(2'd3, 1'b1);
    send(2'd3, 1'b0);
    send(2'd3, 1'b1);
    check("arst.busy_pre", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst.en", en, 0);
    check("arst.x", outx, 0);
    check("arst.y", outy, 0);
    check("arst.busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    send(2'd1, 1'b1);
    check("arst.en1", en, 0);
    send(2'd1, 1'b1);
    expect_sym("arst.qpsk", 1024, 1024);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
Parametrised Gray-coded constellation mapper for the OFDM transmit chain, the next generation of the fixed QPSK modulator. It accepts a serial bit stream from the encoder and packs 1, 2, 4 or 6 bits per symbol according to a run-time mode (BPSK/QPSK/16-QAM/64-QAM). It emits registered signed I/Q samples with a one-cycle valid strobe toward the IFFT input buffer. The mode is latched per symbol, so it can change on the fly without corrupting symbols.

Parameters:
OUT_W, 16, width of signed outx/outy
UNIT, 1024, output amplitude of constellation level 1; 7*UNIT must fit in signed OUT_W (elaboration-time check)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in  input  1  serial coded bit
encoder_en  input  1  in is valid this cycle
mode  input  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=64-QAM; sampled at first bit of each symbol
flush  input  1  synchronous discard of any partially collected symbol
en  output  1  one-cycle strobe: outx/outy carry a new symbol
outx  output  OUT_W  signed in-phase sample
outy  output  OUT_W  signed quadrature sample
busy  output  1  high while a partial symbol is held (bit count != 0)

Behaviour:
- Reset (async assert): en=0, outx=0, outy=0, busy=0, bit count=0, shift register=0, latched mode=BPSK.
- Bits per symbol N: BPSK 1, QPSK 2, 16-QAM 4, 64-QAM 6. k=N/2 bits per axis (BPSK k=1, I only).
- Bit collection: each clk with encoder_en=1 and flush=0 shifts in into the shift register and increments the count. First received bit = b0.
- Mode latch: when encoder_en=1 and count==0, mode is captured into the latched mode for that symbol. Mode changes while count!=0 have no effect until the next symbol.
- Symbol completion: when the captured bit makes count==N, the count returns to 0. On that same edge outx/outy are registered and en=1 for exactly one cycle. Latency: outputs are valid in the cycle after the edge that sampled the last bit.
- outx/outy hold their last value between strobes. en is 0 in every cycle that is not a completion.
- encoder_en=0: state holds with no timeout. Gaps of any length inside a symbol are legal.
- flush=1: count is cleared to 0 and the partial bits are dropped. flush with encoder_en in the same cycle: flush wins and the bit is discarded. flush does not alter outx/outy/en, except that en still falls to 0.
- Axis split: I uses b0..b(k-1), Q uses bk..b(2k-1). BPSK: Q=0.
- Per-axis Gray levels:
  - k=1: 0→-1, 1→+1.
  - k=2: 00→-3, 01→-1, 11→+1, 10→+3.
  - k=3: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Output value = level*UNIT, sign-extended to OUT_W. There is no per-mode normalisation; downstream scaling is applied separately.
- busy = (count != 0), registered.
- Reset mid-symbol: the partial symbol is lost, outputs return to reset values immediately, and the next accepted bit starts a new symbol with freshly sampled mode.

Test Plan:
- Reset, mode=1, bits 1,0 with encoder_en continuous → one cycle after 2nd bit edge: en=1, outx=+1024, outy=-1024; en=0 next cycle.
- mode=2, bits 1,0,0,1 → outx=+3072, outy=-1024. mode=3, bits 1,0,0,0,1,1 → outx=+7168, outy=-3072.
- mode=0, bits 0,1,1 → three strobes on consecutive cycles: (-1024,0), (+1024,0), (+1024,0).
- mode=3 at first bit, switched to 1 after bit 2; six bits sent → exactly one strobe after bit 6, 64-QAM mapping, no strobe after bit 2. The next symbol uses QPSK.
- 16-QAM: 2 bits, 5-cycle encoder_en gap, flush asserted together with a 3rd bit, then 4 bits 0,0,0,0 → busy drops at flush, single strobe (-3072,-3072), no strobe from the discarded bits.
- Assert reset asynchronously between clock edges mid-64-QAM symbol → en/outx/outy/busy go to 0 without a clock edge. After release a full QPSK symbol maps correctly.
